player_datapath: RTL

- Datapath stage directly downstream of the game control FSM.
- Consumes its ld_x/ld_y/ld_colour load strobes and its one-cycle draw start pulse.
- Autonomously animates a SIZE×SIZE player sprite across the 160×120 VGA frame: draw, wait one frame, erase, move, redraw.
- Streams pixel writes (x_out, y_out, colour_out, plot) to the VGA adapter and returns finish to the control FSM.

---
 rtl/player_datapath.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/player_datapath.sv
// -----------------------------------------------------------------------------
// player_datapath
//
// Sprite animation datapath sitting behind the game control FSM. Once told to
// draw, it paints a SIZE x SIZE player sprite, waits one frame, erases it with
// the background colour, steps it right (and up/down under button control),
// and repeats until the sprite reaches END_X or a collision is reported. It
// then parks in DONE with finish held high until reset.
//
// Ports:
//   clock        in   system clock, all state on rising edge
//   resetn       in   asynchronous active-low reset
//   ld_x         in   load x_in into the position register (IDLE only)
//   ld_y         in   load y_in into the position register (IDLE only)
//   ld_colour    in   load colour_in into the colour register (IDLE only)
//   draw         in   start pulse, honoured in IDLE only
//   x_in[7:0]    in   start x
//   y_in[6:0]    in   start y
//   colour_in    in   sprite colour
//   move_up      in   level, move sprite up at next MOVE
//   move_down    in   level, move sprite down at next MOVE
//   hit          in   level from collision detector, sampled in MOVE
//   x_out[7:0]   out  pixel x to VGA adapter
//   y_out[6:0]   out  pixel y to VGA adapter
//   colour_out   out  pixel colour
//   plot         out  pixel write strobe
//   finish       out  sticky end-of-run flag
//
// Control handshake: draw is a single-cycle request that is only accepted in
// IDLE; there is no ready signal, requests in any other state are dropped.
// plot is a write strobe with no back-pressure: every cycle it is high, the
// VGA adapter must take (x_out, y_out, colour_out). finish is sticky and
// remains high until resetn is asserted.
// -----------------------------------------------------------------------------
module player_datapath #(
   parameter int unsigned SIZE_LOG2   = 2,
   parameter int unsigned STEP        = 1,
   parameter int unsigned END_X       = 156,
   parameter int unsigned MAX_Y       = 116,
   parameter int unsigned FRAME_TICKS = 833333,
   parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       ld_x,
   input  logic       ld_y,
   input  logic       ld_colour,
   input  logic       draw,
   input  logic [7:0] x_in,
   input  logic [6:0] y_in,
   input  logic [2:0] colour_in,
   input  logic       move_up,
   input  logic       move_down,
   input  logic       hit,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour_out,
   output logic       plot,
   output logic       finish
);

   localparam int unsigned CW = 2 * SIZE_LOG2;
   localparam int unsigned FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LAST   = '1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRAW  = 3'd1,
      S_WAIT  = 3'd2,
      S_ERASE = 3'd3,
      S_MOVE  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t          state_q;
   logic [7:0]      x_q;
   logic [6:0]      y_q;
   logic [2:0]      colour_q;
   logic [CW-1:0]   cnt_q;
   logic [FW-1:0]   frame_q;
   logic            pending_q;

   logic [7:0]      x_out_q;
   logic [6:0]      y_out_q;
   logic [2:0]      colour_out_q;
   logic            plot_q;
   logic            finish_q;

   // Next position computed for the MOVE state.
   logic [8:0]      x_sum;
   logic [7:0]      y_sum;
   logic [7:0]      x_move_d;
   logic [6:0]      y_move_d;
   logic            x_end_d;

   // Pixel offset inside the sprite: low bits walk x fastest (raster order).
   logic [7:0]      px;
   logic [6:0]      py;

   assign px = x_q + 8'(cnt_q[SIZE_LOG2-1:0]);
   assign py = y_q + 7'(cnt_q[CW-1:SIZE_LOG2]);

   always_comb begin
      // Nine-bit sum so that a step near the right edge cannot wrap.
      x_sum    = {1'b0, x_q} + 9'(STEP);
      y_sum    = {1'b0, y_q} + 8'(STEP);
      x_end_d  = (x_sum >= 9'(END_X));
      x_move_d = x_end_d ? 8'(END_X) : x_sum[7:0];
      y_move_d = y_q;
      if (move_up && !move_down) begin
         y_move_d = (y_q >= 7'(STEP)) ? (y_q - 7'(STEP)) : 7'd0;
      end else if (move_down && !move_up) begin
         y_move_d = (y_sum > 8'(MAX_Y)) ? 7'(MAX_Y) : y_sum[6:0];
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         colour_q     <= '0;
         cnt_q        <= '0;
         frame_q      <= '0;
         pending_q    <= 1'b0;
         x_out_q      <= '0;
         y_out_q      <= '0;
         colour_out_q <= '0;
         plot_q       <= 1'b0;
         finish_q     <= 1'b0;
      end else begin
         // Outputs follow the state/counter of the current cycle, so they
         // trail the FSM by exactly one clock.
         plot_q   <= (state_q == S_DRAW) || (state_q == S_ERASE);
         finish_q <= (state_q == S_DONE);
         if ((state_q == S_DRAW) || (state_q == S_ERASE)) begin
            x_out_q      <= px;
            y_out_q      <= py;
            colour_out_q <= (state_q == S_DRAW) ? colour_q : BG_COLOUR;
         end

         case (state_q)
            S_IDLE: begin
               if (ld_x)      x_q      <= x_in;
               if (ld_y)      y_q      <= y_in;
               if (ld_colour) colour_q <= colour_in;
               if (draw) begin
                  cnt_q   <= '0;
                  state_q <= S_DRAW;
               end
            end
            S_DRAW: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  frame_q <= '0;
                  state_q <= pending_q ? S_DONE : S_WAIT;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_WAIT: begin
               if (frame_q == FRAME_LAST) begin
                  frame_q <= '0;
                  cnt_q   <= '0;
                  state_q <= S_ERASE;
               end else begin
                  frame_q <= frame_q + FW'(1);
               end
            end
            S_ERASE: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_MOVE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_MOVE: begin
               x_q <= x_move_d;
               y_q <= y_move_d;
               // Finishing still goes through one more DRAW so the final
               // position is visible on screen.
               if (x_end_d || hit) pending_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= S_DRAW;
            end
            S_DONE: begin
               state_q <= S_DONE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign x_out      = x_out_q;
   assign y_out      = y_out_q;
   assign colour_out = colour_out_q;
   assign plot       = plot_q;
   assign finish     = finish_q;

endmodule
